// File: rtl/sysarray_feeder.sv
// ============================================================================
// Module      : sysarray_feeder
// Description : Operand feeder for the sysarray systolic array. Captures one
//               n x n operand pair (A column-by-column, B row-by-row) through a
//               valid/ready load port. On start it streams 3n per-step lane
//               vectors (arr1/arr2) with a step index (flg).
//               Optional build macro SYSARRAY_FEEDER_SKEW_EN: when defined,
//               lane i of both vectors is delayed by i steps (diagonal skew).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sysarray_feeder #(
    parameter int N = 31,   // MSB index of one operand word
    parameter int n = 3     // array dimension (lanes per vector, beats per load)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [n*(N+1)-1:0]   load_a,
    input  logic [n*(N+1)-1:0]   load_b,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [6:0]           flg,
    output logic [n*(N+1)-1:0]   arr1,
    output logic [n*(N+1)-1:0]   arr2
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_W    = N + 1;                    // word width
    localparam int         c_VW   = n * c_W;                  // vector width
    localparam int         c_BW   = (n > 1) ? $clog2(n) : 1;  // beat counter width
    localparam logic [6:0] c_LAST = 7'(3 * n - 1);            // final stream step

    localparam logic [1:0] c_LOAD   = 2'd0;
    localparam logic [1:0] c_ARMED  = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_BW-1:0]  r_beat;
    logic             w_accept;
    logic             w_last_beat;

    // Slot k of r_a holds column k of A (lane i = A[i][k]);
    // slot k of r_b holds row k of B (lane j = B[k][j]).
    logic [c_VW-1:0]  r_a [n];
    logic [c_VW-1:0]  r_b [n];

    logic [6:0]       w_step;       // step whose data is presented after this edge
    logic [c_VW-1:0]  w_step_a;
    logic [c_VW-1:0]  w_step_b;

    logic [6:0]       w_flg_nxt;
    logic [c_VW-1:0]  w_arr1_nxt;
    logic [c_VW-1:0]  w_arr2_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_ready_nxt;

    logic [6:0]       r_flg;
    logic [c_VW-1:0]  r_arr1;
    logic [c_VW-1:0]  r_arr2;
    logic             r_busy;
    logic             r_done;
    logic             r_load_ready;

    // A beat is taken only while collecting operands; load_ready is high
    // throughout LOAD, so the state qualifier keeps ARMED/STREAM beats out.
    assign w_accept    = (r_state == c_LOAD) && load_valid && r_load_ready;
    assign w_last_beat = (r_beat == c_BW'(n - 1));

    // Entering STREAM from ARMED presents step 0; inside STREAM the next step.
    assign w_step = (r_state == c_STREAM) ? (r_flg + 7'd1) : 7'd0;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_LOAD: begin
                if (w_accept && w_last_beat) begin
                    w_state_nxt = c_ARMED;
                end
            end
            c_ARMED: begin
                // start wins over a simultaneous load beat
                if (start) begin
                    w_state_nxt = c_STREAM;
                end
            end
            c_STREAM: begin
                if (r_flg == c_LAST) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_LOAD;
            end
            default: begin
                w_state_nxt = c_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Beat counter: counts accepted beats, wraps to 0 after the last one
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
        end else if (w_accept) begin
            r_beat <= w_last_beat ? '0 : (r_beat + c_BW'(1));
        end
    end

    // ------------------------------------------------------------------------
    // Operand store: slot selected by the beat counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < n; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < n; k++) begin
                if (r_beat == c_BW'(k)) begin
                    r_a[k] <= load_a;
                    r_b[k] <= load_b;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Step data select: lane i takes slot k whose step matches w_step.
    // Unskewed, every lane reads slot t; skewed, lane i reads slot t-i.
    // Steps with no matching slot leave the lane at zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_step_a = '0;
        w_step_b = '0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < n; k++) begin
`ifdef SYSARRAY_FEEDER_SKEW_EN
                if (w_step == 7'(k + i)) begin
`else
                if (w_step == 7'(k)) begin
`endif
                    w_step_a[i*c_W +: c_W] = r_a[k][i*c_W +: c_W];
                    w_step_b[i*c_W +: c_W] = r_b[k][i*c_W +: c_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered outputs, keyed on next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_flg_nxt   = 7'd0;
        w_arr1_nxt  = '0;
        w_arr2_nxt  = '0;
        w_busy_nxt  = (w_state_nxt == c_STREAM);
        w_done_nxt  = (w_state_nxt == c_DONE);
        w_ready_nxt = (w_state_nxt == c_LOAD);
        if (w_state_nxt == c_STREAM) begin
            w_flg_nxt  = w_step;
            w_arr1_nxt = w_step_a;
            w_arr2_nxt = w_step_b;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flg        <= 7'd0;
            r_arr1       <= '0;
            r_arr2       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_flg        <= w_flg_nxt;
            r_arr1       <= w_arr1_nxt;
            r_arr2       <= w_arr2_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_load_ready <= w_ready_nxt;
        end
    end

    assign flg        = r_flg;
    assign arr1       = r_arr1;
    assign arr2       = r_arr2;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule

`default_nettype wire
